// File: rtl/mem_bus_scheduler.sv
// Round-robin owner scheduler for the shared memory bus: one-hot registered grant,
// turnaround gap between owners and a hold-limit watchdog that revokes overstaying masters.
module mem_bus_scheduler #(
    parameter int unsigned N           = 4,
    parameter int unsigned IDW         = 2,
    parameter int unsigned MAX_HOLD    = 256,
    parameter int unsigned HOLDW       = 9,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_done,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_bus_busy,
    output logic           o_timeout,
    output logic [IDW-1:0] o_timeout_id
);

    typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_t;

    state_t           r_state,      w_state_nxt;
    logic [N-1:0]     r_grant,      w_grant_nxt;
    logic [IDW-1:0]   r_grant_id,   w_grant_id_nxt;
    logic [IDW-1:0]   r_ptr,        w_ptr_nxt;
    logic [HOLDW-1:0] r_hold,       w_hold_nxt;
    logic [3:0]       r_turn,       w_turn_nxt;
    logic             r_timeout,    w_timeout_nxt;
    logic [IDW-1:0]   r_timeout_id, w_timeout_id_nxt;

    int unsigned      w_start;
    logic [2*N-1:0]   w_req_dbl;
    logic [N-1:0]     w_req_rot;
    logic [IDW-1:0]   w_winner;
    logic             w_release;
    logic             w_expire;

    // Rotate requests so the master after the last winner sits at bit 0, then take the
    // lowest set bit; the loop runs downwards so the lowest index is the final assignment.
    always_comb begin : arbiter
        w_start   = (32'(r_ptr) + 32'd1) % N;
        w_req_dbl = {i_req, i_req};
        w_req_rot = N'(w_req_dbl >> w_start);
        w_winner  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_winner = IDW'((w_start + 32'(i)) % N);
            end
        end
    end

    // r_grant is one-hot while owning, so masking picks out the owner's own lines only.
    assign w_release = (|(i_done & r_grant)) | ~(|(i_req & r_grant));
    assign w_expire  = (MAX_HOLD != 0) && (r_hold == HOLDW'(MAX_HOLD - 1));

    always_comb begin : fsm
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_grant_id_nxt   = r_grant_id;
        w_ptr_nxt        = r_ptr;
        w_hold_nxt       = r_hold;
        w_turn_nxt       = r_turn;
        w_timeout_nxt    = 1'b0;
        w_timeout_id_nxt = r_timeout_id;

        case (r_state)
            StIdle: begin
                if (|i_req) begin
                    w_state_nxt    = StOwn;
                    w_grant_nxt    = N'(1) << w_winner;
                    w_grant_id_nxt = w_winner;
                    w_ptr_nxt      = w_winner;
                    w_hold_nxt     = '0;
                end
            end
            StOwn: begin
                if (w_release || w_expire) begin
                    w_state_nxt    = StTurn;
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                    w_turn_nxt     = 4'(TURN_CYCLES - 1);
                    // A voluntary release in the same cycle wins over the watchdog.
                    if (!w_release) begin
                        w_timeout_nxt    = 1'b1;
                        w_timeout_id_nxt = r_grant_id;
                    end
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            StTurn: begin
                if (r_turn == '0) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_turn_nxt = r_turn - 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_ptr        <= IDW'(N - 1);
            r_hold       <= '0;
            r_turn       <= '0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_ptr        <= w_ptr_nxt;
            r_hold       <= w_hold_nxt;
            r_turn       <= w_turn_nxt;
            r_timeout    <= w_timeout_nxt;
            r_timeout_id <= w_timeout_id_nxt;
        end
    end

    assign o_grant      = r_grant;
    assign o_grant_id   = r_grant_id;
    assign o_bus_busy   = (r_state != StIdle);
    assign o_timeout    = r_timeout;
    assign o_timeout_id = r_timeout_id;

    a_grant_onehot0 : assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0(r_grant));
    a_timeout_no_grant : assert property (@(posedge i_clk) disable iff (i_reset)
        r_timeout |-> (r_grant == '0));

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Drives two scheduler instances (different hold limit / turnaround) with shared stimulus and
// compares every cycle against a tenure-level reference model.
module tb_mem_bus_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;

    logic [3:0] grant   [2];
    logic [1:0] gid     [2];
    logic       busy    [2];
    logic       tmo     [2];
    logic [1:0] tmo_id  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    localparam int MAXH [2] = '{8, 4};
    localparam int TURN [2] = '{1, 3};

    // Reference model: who owns the bus, how long they have owned it, how many gap cycles
    // remain before the next arbitration, and who won last.
    int   m_owner [2];
    int   m_owned [2];
    int   m_gap   [2];
    int   m_last  [2];
    logic m_to    [2];
    int   m_toid  [2];

    always #5 clk = ~clk;

    mem_bus_scheduler #(
        .N(4), .IDW(2), .MAX_HOLD(8), .HOLDW(9), .TURN_CYCLES(1)
    ) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_done(done),
        .o_grant(grant[0]), .o_grant_id(gid[0]), .o_bus_busy(busy[0]),
        .o_timeout(tmo[0]), .o_timeout_id(tmo_id[0])
    );

    mem_bus_scheduler #(
        .N(4), .IDW(2), .MAX_HOLD(4), .HOLDW(9), .TURN_CYCLES(3)
    ) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_done(done),
        .o_grant(grant[1]), .o_grant_id(gid[1]), .o_bus_busy(busy[1]),
        .o_timeout(tmo[1]), .o_timeout_id(tmo_id[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_owned[k] = 0;
            m_gap[k]   = 0;
            m_last[k]  = 3;
            m_to[k]    = 1'b0;
            m_toid[k]  = 0;
        end
    endtask

    task automatic model_edge(input logic [3:0] rq, input logic [3:0] dn);
        for (int k = 0; k < 2; k++) begin
            m_to[k] = 1'b0;
            if (m_owner[k] >= 0) begin
                m_owned[k]++;
                if (dn[m_owner[k]] || !rq[m_owner[k]]) begin
                    m_owner[k] = -1;
                    m_gap[k]   = TURN[k];
                end else if (MAXH[k] != 0 && m_owned[k] == MAXH[k]) begin
                    m_to[k]    = 1'b1;
                    m_toid[k]  = m_owner[k];
                    m_owner[k] = -1;
                    m_gap[k]   = TURN[k];
                end
            end else if (m_gap[k] > 0) begin
                m_gap[k]--;
            end else if (rq != 4'b0) begin
                for (int j = 1; j <= 4; j++) begin
                    if (m_owner[k] < 0 && rq[(m_last[k] + j) % 4]) begin
                        m_owner[k] = (m_last[k] + j) % 4;
                    end
                end
                m_last[k]  = m_owner[k];
                m_owned[k] = 0;
            end
        end
    endtask

    task automatic check_all(input string stage);
        string nm;
        for (int k = 0; k < 2; k++) begin
            nm = $sformatf("%s.%s", stage, (k == 0) ? "A" : "B");
            check({nm, ".grant"}, 32'(grant[k]),
                  (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0);
            check({nm, ".grant_id"}, 32'(gid[k]), (m_owner[k] >= 0) ? m_owner[k] : 0);
            check({nm, ".bus_busy"}, 32'(busy[k]),
                  32'((m_owner[k] >= 0) || (m_gap[k] > 0)));
            check({nm, ".timeout"}, 32'(tmo[k]), 32'(m_to[k]));
            check({nm, ".timeout_id"}, 32'(tmo_id[k]), m_toid[k]);
        end
    endtask

    task automatic step(input string stage);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(req, done);
        cyc++;
        #1;
        check_all(stage);
    endtask

    task automatic mid_reset(input string stage);
        rst = 1'b1;
        #1;
        model_reset();
        check_all({stage, ".async_rst"});
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        req  = 4'b0;
        done = 4'b0;
        for (int i = 0; i < n; i++) step("idle");
    endtask

    logic [3:0] rr_log[$];
    logic [3:0] order[$];
    int         zruns[$];
    logic [3:0] cur;
    int         zrun;
    int         run;
    int         n_to;
    int         p_flip;
    int         p_done;
    logic       seen;
    logic [3:0] exp_order[5];

    initial begin
        rst  = 1'b1;
        req  = 4'b0;
        done = 4'b0;
        model_reset();
        step("reset");
        step("reset");
        rst = 1'b0;

        // Single master: grant after edge 1, released at edge 5, idle after edge 6.
        req = 4'b0001;
        step("single");
        check("single.first_grant", 32'(grant[0]), 32'h1);
        check("single.first_busy", 32'(busy[0]), 32'h1);
        for (int i = 0; i < 3; i++) step("single");
        req = 4'b0000;
        step("single");
        check("single.turn_grant", 32'(grant[0]), 32'h0);
        step("single");
        check("single.idle_busy", 32'(busy[0]), 32'h0);
        idle(4);

        // Round-robin from reset, each owner of A finishing on its 3rd cycle.
        mid_reset("rr");
        req = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            done = (m_owner[0] >= 0 && m_owned[0] == 2) ? (4'b1 << m_owner[0]) : 4'b0;
            step("rr");
            rr_log.push_back(grant[0]);
        end
        cur  = 4'b0;
        zrun = 0;
        foreach (rr_log[i]) begin
            if (rr_log[i] == 4'b0) begin
                zrun++;
            end else if (rr_log[i] != cur) begin
                if (cur != 4'b0) zruns.push_back(zrun);
                order.push_back(rr_log[i]);
                cur  = rr_log[i];
                zrun = 0;
            end
        end
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("rr.tenures", 32'(order.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            check($sformatf("rr.order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        end
        for (int i = 0; i < 4 && i < zruns.size(); i++) begin
            check($sformatf("rr.gap%0d", i), zruns[i], 2);
        end

        // Watchdog on A: master 2 held forever is revoked after exactly 8 owned cycles.
        done = 4'b0;
        req  = 4'b0100;
        run  = 0;
        n_to = 0;
        for (int i = 0; i < 40; i++) begin
            step("wd");
            if (grant[0] == 4'b0100) begin
                run++;
            end else if (tmo[0]) begin
                n_to++;
                check("wd.hold_len", run, 8);
                check("wd.timeout_id", 32'(tmo_id[0]), 32'h2);
                run = 0;
            end
        end
        check("wd.timeouts_seen", 32'(n_to >= 2), 32'h1);
        req  = 4'b0110;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step("wd2");
            if (!seen && grant[0] != 4'b0 && grant[0] != 4'b0100) begin
                seen = 1'b1;
                check("wd2.next_owner", 32'(grant[0]), 32'h2);
            end
        end
        check("wd2.handoff_seen", 32'(seen), 32'h1);
        idle(6);

        // Foreign done / foreign request drop must not disturb owner 1.
        req = 4'b0010;
        step("foreign");
        req = 4'b1010;
        step("foreign");
        req  = 4'b0010;
        done = 4'b0100;
        step("foreign");
        done = 4'b0;
        check("foreign.grant", 32'(grant[0]), 32'h2);
        step("foreign");
        check("foreign.grant_hold", 32'(grant[0]), 32'h2);
        idle(6);

        // Release on B's 4th cycle collides with its watchdog: release wins.
        req  = 4'b0001;
        n_to = 0;
        for (int i = 0; i < 20; i++) begin
            done = (m_owner[1] >= 0 && m_owned[1] == 3) ? (4'b1 << m_owner[1]) : 4'b0;
            step("collide");
            if (tmo[1]) n_to++;
        end
        check("collide.no_timeout", n_to, 0);
        idle(6);

        // Asynchronous reset in the middle of master 3's tenure.
        req = 4'b1000;
        step("arst");
        step("arst");
        check("arst.owner3", 32'(grant[0]), 32'h8);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst.grant_now", 32'(grant[0]), 32'h0);
        check("arst.busy_now", 32'(busy[0]), 32'h0);
        check_all("arst");
        step("arst");
        req = 4'b1001;
        rst = 1'b0;
        step("arst");
        check("arst.first_after_A", 32'(grant[0]), 32'h1);
        check("arst.first_after_B", 32'(grant[1]), 32'h1);

        // Random segments with varying request churn and done density.
        for (int s = 0; s < 40; s++) begin
            p_flip = int'($urandom_range(1, 40));
            p_done = int'($urandom_range(0, 30));
            for (int c = 0; c < 40; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if (int'($urandom_range(0, 99)) < p_flip) req[b] = ~req[b];
                    done[b] = (int'($urandom_range(0, 99)) < p_done);
                end
                step("rnd");
                if ($urandom_range(0, 299) == 0) mid_reset("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_scheduler.md
Name: mem_bus_scheduler

Overview:
- Central scheduler for the shared memory interconnect bus (bus_addr/bus_data/bus_en).
- Replaces the daisy-chained grant_in/grant_out path between dcache, system-controller read master, icache and DMA.
- Accepts one request line per master and grants the bus to exactly one master at a time, round-robin.
- Inserts a bus turnaround gap between owners and revokes the bus from masters that overstay a hold limit.

Parameters:
N, 4, number of bus masters (index 0 dcache, 1 sys controller, 2 icache, 3 dma)
IDW, 2, width of grant_id/timeout_id; must be >= clog2(N)
MAX_HOLD, 256, max consecutive owned cycles before forced revoke; 0 disables the watchdog
HOLDW, 9, hold counter width; must be able to hold MAX_HOLD
TURN_CYCLES, 1, idle bus cycles between owners; legal range 1..15

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req  in  N  per-master bus request, level; held until done or until granted-and-finished
done  in  N  per-master release pulse; honoured only from the current owner
grant  out  N  one-hot bus grant, registered; all-zero when no owner
grant_id  out  IDW  index of current owner; valid only while grant != 0, else 0
bus_busy  out  1  high in every state except IDLE
timeout  out  1  one-cycle pulse when the watchdog revokes an owner
timeout_id  out  IDW  index of revoked master; held until the next timeout

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - state=IDLE; grant=0; grant_id=0; bus_busy=0; timeout=0; timeout_id=0.
  - hold counter=0; turn counter=0; rr pointer=N-1, so master 0 has first priority.
- States: IDLE, OWN, TURN.
- IDLE:
  - If req!=0 at the clock edge, winner = first set bit searching (ptr+1) mod N upward with wrap.
  - At that edge: grant=onehot(winner); grant_id=winner; ptr=winner; hold=0; state=OWN.
  - Grant latency: 1 edge from req sampled high in IDLE.
  - If req==0, stay in IDLE.
- OWN:
  - Release on either condition: done[owner]=1 or req[owner]=0 at the edge.
  - Release action: grant=0; grant_id=0; turn counter=TURN_CYCLES-1; state=TURN.
  - Otherwise hold increments.
  - Watchdog: if MAX_HOLD!=0 and hold==MAX_HOLD-1 at the edge, revoke as for release, plus timeout=1 for one cycle and timeout_id=owner.
  - Revoke therefore happens after exactly MAX_HOLD granted cycles.
  - Release and timeout in the same cycle: treat as release; timeout stays 0.
  - done/req from non-owners never affect the owner; their requests stay pending.
- TURN:
  - grant=0; bus_busy=1.
  - Counter decrements each edge; at 0, state=IDLE.
  - req is not sampled for arbitration in TURN.
- Fairness:
  - ptr updates only on a new grant.
  - A master that releases or is revoked is lowest priority at the next arbitration.
  - With all N requesting, each waits at most N-1 tenures.
- Overall gap: an owner released at edge k leaves the next grant visible after edge k+TURN_CYCLES+1.
- grant is always one-hot or zero; it never changes directly from one master to another.
- timeout is forced 0 in every cycle except the revoke cycle.

Test Plan:
- Single master, TURN_CYCLES=1:
  - Stimulus: req=0001 before edge 1; req drops before edge 5.
  - Response: after edge 1, grant=0001, grant_id=0, bus_busy=1. After edge 5, grant=0 (TURN). After edge 6, IDLE with bus_busy=0.
- Round-robin, req=1111 held, each owner pulses done on its 3rd granted cycle:
  - Grant order is 0001, 0010, 0100, 1000, 0001.
  - Every handoff shows exactly 2 zero-grant cycles (1 TURN + 1 IDLE).
- Watchdog, MAX_HOLD=8, req=0100 held forever:
  - grant=0100 for exactly 8 cycles, then grant=0 with timeout=1 for one cycle and timeout_id=2.
  - Master 2 is re-granted after the TURN+IDLE gap.
  - With req=0110, master 1 wins instead.
- Foreign release: owner=1 (grant=0010), pulse done=0100 and drop req[3] → grant stays 0010, no state change.
- Release+timeout collision, MAX_HOLD=4: owner pulses done on its 4th cycle → release with timeout=0 and timeout_id unchanged.
- Async reset mid-OWN with grant=1000: assert reset between edges → grant=0 and bus_busy=0 immediately, before the next edge. After reset release with req=1001, the first grant goes to master 0 (0001).
